gf_mixcol_seq: RTL and testbench

Sequencer for a shared GF(2^8) constant-multiply datapath that applies a 4x4 circulant byte matrix (MixColumns-class linear layer) to one 32-bit column at a time. It accepts a column on a valid/ready handshake, computes one output byte per cycle over four cycles, and presents the result on a valid/ready output. It sits between the S-box/table stage and the round-key XOR in the white-box round pipeline.

---
 rtl/gf_mixcol_pkg.sv | 32 +++
 rtl/gf_mixcol_row.sv | 28 ++
 rtl/gf_mixcol_seq.sv | 105 ++++++++++
 tb/tb_gf_mixcol_seq.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_mixcol_pkg.sv
// Shared definitions for the GF(2^8) circulant column mixer:
// FSM state encoding, default reduction polynomial, the forward and inverse
// coefficient sets, and the constant-multiply helper used by the row datapath.
package gf_mixcol_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [8:0]  GF_POLY_DEFAULT = 9'h11B;
   // Byte k holds C[k]; forward is (02,03,01,01), inverse is (0E,0B,0D,09).
   localparam logic [31:0] COEF_FWD        = 32'h01010302;
   localparam logic [31:0] COEF_INV        = 32'h090D0B0E;

   // Shift-and-add multiply in GF(2^8); poly[8] is implied by the carry-out test.
   function automatic logic [7:0] gf8_mul(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [8:0] poly);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ poly[7:0]) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

endpackage

// File: rtl/gf_mixcol_row.sv
// Combinational row datapath: one output byte of the circulant product,
// o_row = XOR_i C[(i - row) mod 4] * s_i over GF(2^8).
module gf_mixcol_row
   import gf_mixcol_pkg::*;
#(
   parameter logic [8:0] POLY = GF_POLY_DEFAULT
) (
   input  logic [31:0] i_col,
   input  logic [31:0] i_coef,
   input  logic [1:0]  i_row,
   output logic [7:0]  o_row
);

   logic [7:0] w_acc;

   // Accumulate the four products; the coefficient index wraps mod 4 via 2-bit subtraction.
   always_comb begin
      w_acc = '0;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] k;
         k = i[1:0] - i_row;
         w_acc = w_acc ^ gf8_mul(i_col[8*i +: 8], i_coef[8*k +: 8], POLY);
      end
   end

   assign o_row = w_acc;

endmodule

// File: rtl/gf_mixcol_seq.sv
// Sequencer for a shared GF(2^8) row datapath applying a 4x4 circulant byte
// matrix to one 32-bit column, one output byte per cycle over four cycles.
// Optional feature: define GFMIX_INV_EN to add the inv port, which selects the
// inverse coefficient set (sampled when a column is accepted).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; valid/data are held by the source until that edge, and ready
// never depends on the same interface's valid. in_ready and out_valid are
// decoded from the state (plus out_ready for the DONE-cycle accept).
module gf_mixcol_seq
   import gf_mixcol_pkg::*;
#(
   parameter logic [31:0] COEF  = COEF_FWD,
   parameter logic [8:0]  POLY  = GF_POLY_DEFAULT,
   parameter int          CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
`ifdef GFMIX_INV_EN
   ,
   input  logic             inv
`endif
);

   state_t           r_state;
   logic [31:0]      r_col;
   logic [31:0]      r_coef;
   logic [31:0]      r_out_data;
   logic [1:0]       r_row;
   logic [CNT_W-1:0] r_done_cnt;

   logic [31:0]      w_coef_sel;
   logic [7:0]       w_row_byte;
   logic             w_accept;

`ifdef GFMIX_INV_EN
   assign w_coef_sel = inv ? COEF_INV : COEF;
`else
   assign w_coef_sel = COEF;
`endif

   // Ready in IDLE, or in DONE when the result leaves this same cycle; held low during reset.
   assign in_ready  = !rst && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state == ST_BUSY);
   assign out_data  = r_out_data;
   assign done_cnt  = r_done_cnt;
   assign w_accept  = in_valid && in_ready;

   gf_mixcol_row #(
      .POLY (POLY)
   ) u_row (
      .i_col  (r_col),
      .i_coef (r_coef),
      .i_row  (r_row),
      .o_row  (w_row_byte)
   );

   // Control FSM: latch column, fill one result byte per BUSY cycle, hold in DONE until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_col      <= '0;
         r_coef     <= '0;
         r_out_data <= '0;
         r_row      <= '0;
         r_done_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
            end
            ST_BUSY: begin
               for (int j = 0; j < 4; j++) begin
                  if (r_row == j[1:0]) r_out_data[8*j +: 8] <= w_row_byte;
               end
               r_row <= r_row + 2'd1;
               if (r_row == 2'd3) r_state <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_done_cnt <= r_done_cnt + 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         // Accept overrides the DONE->IDLE move so a back-to-back column goes straight to BUSY.
         if (w_accept) begin
            r_col   <= in_data;
            r_coef  <= w_coef_sel;
            r_row   <= 2'd0;
            r_state <= ST_BUSY;
         end
      end
   end

endmodule

// File: tb/tb_gf_mixcol_seq.sv
// Self-checking bench for gf_mixcol_seq (counter built 4 bits wide to reach wrap).
// Define GFMIX_INV_EN to also exercise the inverse coefficient set.
module tb_gf_mixcol_seq;

   localparam int          CW = 4;
   localparam logic [8:0]  P  = 9'h11B;
   localparam logic [31:0] CF = 32'h01010302;
   localparam logic [31:0] CI = 32'h090D0B0E;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b0;
   logic [31:0]   in_data   = '0;
   logic          in_ready;
   logic          out_valid;
   logic          busy;
   logic [31:0]   out_data;
   logic [CW-1:0] done_cnt;
`ifdef GFMIX_INV_EN
   logic          inv_drv   = 1'b0;
`endif

   int            n_checks  = 0;
   int            n_errors  = 0;
   int            exp_cnt   = 0;
   logic [31:0]   exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   gf_mixcol_seq #(
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done_cnt  (done_cnt)
`ifdef GFMIX_INV_EN
      ,
      .inv       (inv_drv)
`endif
   );

   // ---------------- reference model ----------------
   // Carry-less product followed by polynomial long-division reduction.
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (15'(a) << i);
      for (int t = 14; t >= 8; t--)
         if (p[t]) p = p ^ (15'(P) << (t - 8));
      return p[7:0];
   endfunction

   function automatic logic [31:0] ref_mix(input logic [31:0] col, input logic [31:0] coef);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < 4; i++) begin
            int k;
            k = (i - j + 4) % 4;
            r[8*j +: 8] = r[8*j +: 8] ^ ref_mul(col[8*i +: 8], coef[8*k +: 8]);
         end
      return r;
   endfunction

   function automatic logic [31:0] ref_coef();
`ifdef GFMIX_INV_EN
      return inv_drv ? CI : CF;
`else
      return CF;
`endif
   endfunction

   function automatic logic [31:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   // ---------------- driver tasks ----------------
   // Offer a column; on the accepting edge push its expected result. Returns 1ns after that edge.
   task automatic send_col(input logic [31:0] d);
      int n;
      in_data  = d;
      in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk); #2; n++;
      end
      n_checks++;
      if (!in_ready) begin
         n_errors++;
         $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      end else begin
         exp_q.push_back(ref_mix(d, ref_coef()));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid; lat counts clock edges since the call.
   task automatic wait_out(output logic [31:0] d, output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #2; lat++;
      end
      d = out_data;
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_cnt++;
   endtask

   task automatic hard_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      exp_cnt = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b need 0", busy); end
      @(posedge clk); #1;
      n_checks++; if (out_data !== 32'h0) begin n_errors++; $display("FAIL rst_out_data: got %h need 0", out_data); end
      n_checks++; if (done_cnt !== 4'd0) begin n_errors++; $display("FAIL rst_done_cnt: got %0d need 0", done_cnt); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_release_ready: got %b need 1", in_ready); end
   endtask

   task automatic test_forward();
      logic [31:0] d;
      int lat;
      send_col(32'h455313DB);
      #1;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL fwd_busy: got %b need 1", busy); end
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL fwd_busy_ready: got %b need 0", in_ready); end
      wait_out(d, lat);
      n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL fwd_latency: got %0d need 4", lat); end
      n_checks++; if (d !== 32'hBCA14D8E) begin n_errors++; $display("FAIL fwd_vec1: got %h need %h", d, 32'hBCA14D8E); end
      n_checks++; if (d !== pop_exp()) begin n_errors++; $display("FAIL fwd_vec1_model: got %h", d); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL fwd_done_busy: got %b need 0", busy); end
      take_out();
      n_checks++; if (done_cnt !== 4'd1) begin n_errors++; $display("FAIL fwd_done_cnt: got %0d need 1", done_cnt); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL fwd_valid_drop: got %b need 0", out_valid); end
   endtask

   task automatic test_forward_more();
      logic [31:0] d;
      logic [31:0] e;
      int lat;
      send_col(32'h5C220AF2);
      in_data = $urandom;   // must be ignored while BUSY
      wait_out(d, lat);
      e = pop_exp();
      n_checks++; if (d !== 32'h9D58DC9F) begin n_errors++; $display("FAIL fwd_vec2: got %h need %h", d, 32'h9D58DC9F); end
      n_checks++; if (d !== e) begin n_errors++; $display("FAIL fwd_vec2_model: got %h need %h", d, e); end
      take_out();
      send_col(32'h01010101);
      wait_out(d, lat);
      e = pop_exp();
      n_checks++; if (d !== 32'h01010101) begin n_errors++; $display("FAIL fwd_vec3: got %h need %h", d, 32'h01010101); end
      take_out();
      for (int r = 0; r < 4; r++) begin
         send_col($urandom);
         wait_out(d, lat);
         e = pop_exp();
         n_checks++; if (d !== e) begin n_errors++; $display("FAIL fwd_rand%0d: got %h need %h", r, d, e); end
         take_out();
      end
      n_checks++; if (done_cnt !== exp_cnt[CW-1:0]) begin n_errors++; $display("FAIL fwd_more_cnt: got %0d need %0d", done_cnt, exp_cnt[CW-1:0]); end
   endtask

`ifdef GFMIX_INV_EN
   task automatic test_inverse();
      logic [31:0] d;
      logic [31:0] e;
      int lat;
      inv_drv = 1'b1;
      send_col(32'hBCA14D8E);
      inv_drv = 1'b0;       // sampled only on accept
      wait_out(d, lat);
      e = pop_exp();
      n_checks++; if (d !== 32'h455313DB) begin n_errors++; $display("FAIL inv_vec: got %h need %h", d, 32'h455313DB); end
      n_checks++; if (d !== e) begin n_errors++; $display("FAIL inv_model: got %h need %h", d, e); end
      take_out();
      send_col(32'hBCA14D8E);
      wait_out(d, lat);
      e = pop_exp();
      n_checks++; if (d !== e) begin n_errors++; $display("FAIL inv0_fwd: got %h need %h", d, e); end
      take_out();
   endtask
`endif

   task automatic test_backpressure();
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] nb;
      int lat;
      send_col($urandom);
      wait_out(d, lat);
      nb       = $urandom;
      in_data  = nb;
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #2;
         n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid c%0d: got %b need 1", c, out_valid); end
         n_checks++; if (out_data !== exp_q[0]) begin n_errors++; $display("FAIL bp_data c%0d: got %h need %h", c, out_data, exp_q[0]); end
         n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready c%0d: got %b need 0", c, in_ready); end
      end
      out_ready = 1'b1;
      #1;
      e = pop_exp();
      n_checks++; if (out_data !== e) begin n_errors++; $display("FAIL bp_release_data: got %h need %h", out_data, e); end
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_done_accept: got %b need 1", in_ready); end
      if (in_ready) exp_q.push_back(ref_mix(nb, ref_coef()));
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      exp_cnt++;
      wait_out(d, lat);
      e = pop_exp();
      n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL bp_next_latency: got %0d need 4", lat); end
      n_checks++; if (d !== e) begin n_errors++; $display("FAIL bp_next_data: got %h need %h", d, e); end
      take_out();
      n_checks++; if (done_cnt !== exp_cnt[CW-1:0]) begin n_errors++; $display("FAIL bp_cnt: got %0d need %0d", done_cnt, exp_cnt[CW-1:0]); end
   endtask

   task automatic test_reset_mid_busy();
      logic [31:0] d;
      logic [31:0] e;
      int lat;
      send_col($urandom);
      @(posedge clk); #1;   // second BUSY cycle
      rst = 1'b1;
      exp_q.delete();
      exp_cnt = 0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_rst_busy: got %b need 0", busy); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_valid: got %b need 0", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL mid_rst_ready: got %b need 0", in_ready); end
      n_checks++; if (out_data !== 32'h0) begin n_errors++; $display("FAIL mid_rst_data: got %h need 0", out_data); end
      n_checks++; if (done_cnt !== 4'd0) begin n_errors++; $display("FAIL mid_rst_cnt: got %0d need 0", done_cnt); end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL mid_rst_release: got %b need 1", in_ready); end
      send_col(32'h5C220AF2);
      wait_out(d, lat);
      e = pop_exp();
      n_checks++; if (d !== 32'h9D58DC9F) begin n_errors++; $display("FAIL mid_rst_next: got %h need %h", d, 32'h9D58DC9F); end
      n_checks++; if (d !== e) begin n_errors++; $display("FAIL mid_rst_model: got %h need %h", d, e); end
      take_out();
      n_checks++; if (done_cnt !== 4'd1) begin n_errors++; $display("FAIL mid_rst_cnt_after: got %0d need 1", done_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] nb;
      int lat;
      hard_reset();
      send_col($urandom);
      for (int k = 0; k < 17; k++) begin
         wait_out(d, lat);
         e = pop_exp();
         n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL b2b_latency k%0d: got %0d need 4", k, lat); end
         n_checks++; if (d !== e) begin n_errors++; $display("FAIL b2b_data k%0d: got %h need %h", k, d, e); end
         if (k < 16) begin
            nb        = $urandom;
            in_data   = nb;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready k%0d: got %b need 1", k, in_ready); end
            if (in_ready) exp_q.push_back(ref_mix(nb, ref_coef()));
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            exp_cnt++;
         end else begin
            take_out();
         end
      end
      n_checks++; if (done_cnt !== 4'd1) begin n_errors++; $display("FAIL b2b_wrap: got %0d need 1", done_cnt); end
      n_checks++; if (done_cnt !== exp_cnt[CW-1:0]) begin n_errors++; $display("FAIL b2b_cnt_model: got %0d need %0d", done_cnt, exp_cnt[CW-1:0]); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_forward();
      test_forward_more();
`ifdef GFMIX_INV_EN
      test_inverse();
`endif
      test_backpressure();
      test_reset_mid_busy();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
